// File: rtl/matmul_sequencer_pkg.sv
// Shared defaults, FSM encoding and operand-indexing helper for matmul_sequencer.
package matmul_sequencer_pkg;

    // Default geometry: 4-bit unsigned elements, 3x3 matrices, 10-bit results.
    // 10 bits covers the worst case 3 * 15 * 15 = 675 exactly.
    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_N      = 3;
    localparam int unsigned DEF_ACC_W  = 10;

    // Index width for row/col/k; matches the 2-bit coordinate ports.
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // LSB position of element [r][c] in a row-major flattened matrix.
    function automatic int unsigned elem_lsb(
        input int unsigned r,
        input int unsigned c,
        input int unsigned n,
        input int unsigned w
    );
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Unsigned multiply-accumulate: acc += a * b at full ACC_W width,
// with a synchronous clear that takes priority over accumulation.
module mac_unit
    import matmul_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] prod;

    // Operands widened before the multiply so the product is never truncated.
    always_comb begin
        prod = ACC_W'(a) * ACC_W'(b);
    end

    // Accumulator register: async reset, sync clear, accumulate when enabled.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequential N x N matrix multiplier C = W x X. One MAC per cycle, results
// streamed out row-major over a valid/ready handshake.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     start,
    input  logic [N*N*DATA_W-1:0]    w_flat,
    input  logic [N*N*DATA_W-1:0]    x_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_row,
    output logic [IDX_W-1:0]         out_col,
    output logic                     busy,
    output logic                     done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t                  state;
    logic [IDX_W-1:0]        row;
    logic [IDX_W-1:0]        col;
    logic [IDX_W-1:0]        k;
    logic [N*N*DATA_W-1:0]   w_reg;
    logic [N*N*DATA_W-1:0]   x_reg;
    logic [DATA_W-1:0]       w_op;
    logic [DATA_W-1:0]       x_op;
    logic                    mac_clr;
    logic                    mac_en;
    logic [ACC_W-1:0]        acc;

    // Select W[row][k] and X[k][col] from the captured operands.
    always_comb begin
        w_op = w_reg[elem_lsb(32'(row), 32'(k), N, DATA_W) +: DATA_W];
        x_op = x_reg[elem_lsb(32'(k), 32'(col), N, DATA_W) +: DATA_W];
    end

    // Accumulator held clear while idle and cleared on every accepted element.
    always_comb begin
        mac_clr = (state == ST_IDLE) || ((state == ST_EMIT) && out_ready);
        mac_en  = (state == ST_MAC);
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .clear_n (clear_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (w_op),
        .b       (x_op),
        .acc     (acc)
    );

    // The accumulator is frozen during EMIT, so it doubles as the result register.
    assign out_data = acc;
    assign out_row  = row;
    assign out_col  = col;

    // Sequencer FSM with operand capture, index counters and registered status.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_reg     <= '0;
            x_reg     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_reg <= w_flat;
                        x_reg <= x_flat;
                        row   <= '0;
                        col   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (k == LAST) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if ((row == LAST) && (col == LAST)) begin
                            row   <= '0;
                            col   <= '0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            if (col == LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            state <= ST_MAC;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer (3x3, 4-bit elements).
module tb_matmul_sequencer;

    typedef int unsigned mat_t [9];

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start;
    logic [35:0] w_flat;
    logic [35:0] x_flat;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        busy;
    logic        done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    matmul_sequencer #(
        .DATA_W (4),
        .N      (3),
        .ACC_W  (10)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .start     (start),
        .w_flat    (w_flat),
        .x_flat    (x_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] pack9(input mat_t m);
        logic [35:0] p;
        int unsigned v;
        p = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            v = m[i];
            p[i*4 +: 4] = v[3:0];
        end
        return p;
    endfunction

    // Called at a negedge: starts a job, then follows every output cycle.
    task automatic run_job(input string tag, input mat_t w, input mat_t x, input mat_t exp,
                           input bit stall, input bit restart, input int unsigned exp_cycles);
        int unsigned idx;
        int unsigned cycles;
        int unsigned tick;
        idx = 0;
        cycles = 0;
        tick = 0;
        w_flat = pack9(w);
        x_flat = pack9(x);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        check({tag, "/busy"}, busy, 1);
        while (idx < 9 && cycles < 400) begin
            start = 1'b0;
            out_ready = stall ? ((tick % 4 == 0) || (tick % 4 == 3)) : 1'b1;
            tick++;
            if (out_valid) begin
                check({tag, "/elem"}, {out_row, out_col, out_data},
                      ((idx / 3) << 12) | ((idx % 3) << 10) | exp[idx]);
                if (restart && idx == 4) begin
                    start  = 1'b1;
                    w_flat = '1;
                    x_flat = '0;
                end
                if (out_ready) idx++;
            end else begin
                check({tag, "/no_early_done"}, done, 0);
            end
            @(negedge clk);
            cycles++;
        end
        check({tag, "/count"}, idx, 9);
        check({tag, "/done"}, done, 1);
        check({tag, "/valid_in_done"}, out_valid, 0);
        if (exp_cycles != 0) check({tag, "/cycles"}, cycles, exp_cycles);
        @(negedge clk);
        check({tag, "/done_once"}, done, 0);
        check({tag, "/idle"}, busy, 0);
    endtask

    initial begin
        clear_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        w_flat    = '0;
        x_flat    = '0;
        #1;
        check("rst/valid", out_valid, 0);
        check("rst/busy",  busy, 0);
        check("rst/done",  done, 0);
        check("rst/data",  out_data, 0);
        check("rst/rc",    {out_row, out_col}, 0);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;

        // Start on the very first edge after release; identity W passes X through.
        run_job("ident", '{1,0,0,0,1,0,0,0,1}, '{1,2,3,4,5,6,7,8,9},
                '{1,2,3,4,5,6,7,8,9}, 1'b0, 1'b0, 37);

        run_job("max", '{15,15,15,15,15,15,15,15,15}, '{15,15,15,15,15,15,15,15,15},
                '{675,675,675,675,675,675,675,675,675}, 1'b0, 1'b0, 37);

        run_job("stall", '{1,2,3,4,5,6,7,8,9}, '{9,8,7,6,5,4,3,2,1},
                '{30,24,18,84,69,54,138,114,90}, 1'b1, 1'b0, 0);

        run_job("restart", '{1,2,3,4,5,6,7,8,9}, '{9,8,7,6,5,4,3,2,1},
                '{30,24,18,84,69,54,138,114,90}, 1'b0, 1'b1, 37);

        // Abort during the MAC phase of element (2,0).
        w_flat = pack9('{1,2,3,4,5,6,7,8,9});
        x_flat = pack9('{9,8,7,6,5,4,3,2,1});
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("abort/row", out_row, 2);
        check("abort/col", out_col, 0);
        check("abort/in_mac", out_valid, 0);
        clear_n = 1'b0;
        #1;
        check("abort/valid", out_valid, 0);
        check("abort/busy",  busy, 0);
        check("abort/data",  out_data, 0);
        check("abort/rc",    {out_row, out_col}, 0);
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort/quiet", {done, out_valid, busy}, 0);
        end

        run_job("zero", '{0,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0},
                '{0,0,0,0,0,0,0,0,0}, 1'b0, 1'b0, 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
